// File: rtl/div_pkg.sv
// Shared types and constants for the pipelined divider (div_pipe_n).
package div_pkg;

    localparam int DIV_TAG_MAX = 16;
    localparam int DIV_W_MAX   = 64;

    // Quotient pattern returned on a zero divisor; slice to the operand width.
    localparam logic [DIV_W_MAX-1:0] DIV_DZ_Q = {DIV_W_MAX{1'b1}};

    // Per-stage sideband; the tag field is sized for the widest supported tag.
    typedef struct packed {
        logic                   valid;
        logic [DIV_TAG_MAX-1:0] tag;
        logic                   neg_q;
        logic                   neg_r;
        logic                   dz;
        logic                   ovf;
    } div_sb_t;

    function automatic int div_latency(input int width, input int bps);
        return width / bps + 2;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step on a {remainder, quotient} accumulator.
module div_iter_step
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_nxt
);

    // Upper WIDTH+1 bits of the shifted accumulator versus the zero-extended divisor.
    logic [WIDTH:0] trial;

    assign trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    assign acc_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/div_pipe_n.sv
// Fully pipelined restoring divider, BPS quotient bits per register, global stall.
// Signed support is compiled in only when DIV_SIGNED_EN is defined.
module div_pipe_n
    import div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPS   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz,
    output logic             out_ovf,
    output logic             busy
);

    localparam int N      = WIDTH / BPS;
    localparam int STAGES = div_latency(WIDTH, BPS) - 1;

    // Index 0 = pre-processing, 1..N = iterations, STAGES = post-processing.
    div_sb_t [STAGES:0]             sb_pipe;
    logic    [STAGES:0]             vld_pipe;
    logic    [N:0][2*WIDTH-1:0]     acc_pipe;
    logic    [N:1][2*WIDTH-1:0]     acc_nxt;
    logic    [N-1:0][WIDTH-1:0]     div_pipe;

    div_sb_t          sb_in;
    div_sb_t          sb_last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] q_mag, r_mag, post_q, post_r;
    logic             adv;
    logic             unused_sb;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
`else
    logic unused_signed;
    assign unused_signed = in_signed;
`endif

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign busy      = |vld_pipe;
    assign out_tag   = sb_pipe[STAGES].tag[TAG_W-1:0];
    assign out_dz    = sb_pipe[STAGES].dz;
`ifdef DIV_SIGNED_EN
    assign out_ovf   = sb_pipe[STAGES].ovf;
`else
    assign out_ovf   = 1'b0;
`endif
    assign unused_sb = ^sb_pipe[STAGES];

    for (genvar s = 0; s <= STAGES; s++) begin : g_vld
        assign vld_pipe[s] = sb_pipe[s].valid;
    end

    always_comb begin
        sb_in                = '0;
        sb_in.valid          = in_valid;
        sb_in.tag[TAG_W-1:0] = in_tag;
        sb_in.dz             = (in_divisor == '0);
        mag_a                = in_dividend;
        mag_b                = in_divisor;
`ifdef DIV_SIGNED_EN
        if (in_signed) begin
            sb_in.neg_r = in_dividend[WIDTH-1];
            sb_in.neg_q = in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
            sb_in.ovf   = (in_dividend == MIN) && (&in_divisor);
            if (in_dividend[WIDTH-1]) mag_a = -in_dividend;
            if (in_divisor[WIDTH-1])  mag_b = -in_divisor;
        end
`endif
    end

    for (genvar k = 1; k <= N; k++) begin : g_iter
        logic [BPS:0][2*WIDTH-1:0] chain;
        assign chain[0] = acc_pipe[k-1];
        for (genvar j = 0; j < BPS; j++) begin : g_step
            div_iter_step #(.WIDTH(WIDTH)) u_step (
                .acc     (chain[j]),
                .divisor (div_pipe[k-1]),
                .acc_nxt (chain[j+1])
            );
        end
        assign acc_nxt[k] = chain[BPS];
    end

    // A zero divisor leaves the dividend magnitude in the remainder, so re-applying
    // the dividend sign returns the original dividend without carrying it along.
    always_comb begin
        sb_last = sb_pipe[STAGES-1];
        q_mag   = acc_pipe[N][WIDTH-1:0];
        r_mag   = acc_pipe[N][2*WIDTH-1:WIDTH];
        post_q  = q_mag;
        post_r  = r_mag;
`ifdef DIV_SIGNED_EN
        if (sb_last.neg_q) post_q = -q_mag;
        if (sb_last.neg_r) post_r = -r_mag;
        if (sb_last.ovf) begin
            post_q = MIN;
            post_r = '0;
        end
`endif
        if (sb_last.dz) post_q = DIV_DZ_Q[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_pipe       <= '0;
            acc_pipe      <= '0;
            div_pipe      <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else if (adv) begin
            sb_pipe[0]  <= sb_in;
            acc_pipe[0] <= {{WIDTH{1'b0}}, mag_a};
            div_pipe[0] <= mag_b;
            for (int k = 1; k <= STAGES; k++) sb_pipe[k] <= sb_pipe[k-1];
            for (int k = 1; k <= N; k++)      acc_pipe[k] <= acc_nxt[k];
            for (int k = 1; k < N; k++)       div_pipe[k] <= div_pipe[k-1];
            out_quotient  <= post_q;
            out_remainder <= post_r;
        end
    end

endmodule
